// File: rtl/logic_unit_pkg.sv
// Shared definitions for logic_unit_seq: opcodes, branch conditions, FSM states and shift kinds.
package logic_unit_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOTA = 4'h5;
  localparam logic [3:0] OP_PASS = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_ROTR = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;

  localparam logic [1:0] COND_EQ = 2'b00;
  localparam logic [1:0] COND_NE = 2'b01;
  localparam logic [1:0] COND_GT = 2'b10;
  localparam logic [1:0] COND_LE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SK_SLL,
    SK_SRL,
    SK_SRA,
    SK_ROTR
  } shift_kind_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROTR);
  endfunction

  function automatic shift_kind_e shift_kind(input logic [3:0] op);
    shift_kind_e k;
    unique case (op)
      OP_SRL:  k = SK_SRL;
      OP_SRA:  k = SK_SRA;
      OP_ROTR: k = SK_ROTR;
      default: k = SK_SLL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/logic_unit_seq_shift_step_unit.sv
// Combinational single-step shifter (SLL/SRL/SRA/ROTR by 0..2^SW-1 positions).
module shift_step_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic [WIDTH-1:0] value,
  input  shift_kind_e      kind,
  input  logic [SW-1:0]    step,
  output logic [WIDTH-1:0] out
);

  // NOTE: every variable written in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    out = value;
    unique case (kind)
      SK_SLL:  out = value << step;
      SK_SRL:  out = value >> step;
      SK_SRA:  out = $unsigned($signed(value) >>> step);
      SK_ROTR: out = WIDTH'({value, value} >> step);
      default: out = value;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Execution block: ALU, comparator and shifter behind a start/done handshake.
// Define LOGIC_UNIT_BARREL_EN for single-cycle barrel shifts; default is the iterative shifter.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [1:0]               cond,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic                     shamt_src,
  output logic                     ready,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     overflow,
  output logic                     zero,
  output logic                     negative,
  output logic                     branch_taken,
  output logic                     illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  logic [SHW-1:0]   amount;
  logic [WIDTH-1:0] sh_src;
  logic [WIDTH-1:0] shift_now;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             a_lt_b;
  logic             go_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_bt;
  logic             alu_ill;

  assign amount = shamt_src ? b[SHW-1:0] : shamt;
  assign sh_src = shamt_src ? a : b;
  assign sum    = a + b;
  assign diff   = a - b;
  assign a_lt_b = $signed(a) < $signed(b);
  assign ready  = (state != ST_SHIFT);

`ifdef LOGIC_UNIT_BARREL_EN
  // Barrel path: stage k shifts by 2^k when amount bit k is set.
  logic [WIDTH-1:0] stage [SHW+1];
  assign stage[0] = sh_src;
  for (genvar k = 0; k < SHW; k++) begin : g_barrel
    shift_step_unit #(.WIDTH(WIDTH), .SW(SHW)) u_stage (
      .value (stage[k]),
      .kind  (shift_kind(op)),
      .step  (amount[k] ? SHW'(1 << k) : '0),
      .out   (stage[k+1])
    );
  end
  assign shift_now = stage[SHW];
  assign go_shift  = 1'b0;
`else
  localparam logic [SHW-1:0] STEP_MAX = SHW'(SHIFT_STEP);

  logic [SHW-1:0]   count;
  logic [SHW-1:0]   step;
  logic [WIDTH-1:0] sh_val;
  logic [WIDTH-1:0] step_out;
  shift_kind_e      sh_kind;

  assign step = (count > STEP_MAX) ? STEP_MAX : count;

  shift_step_unit #(.WIDTH(WIDTH), .SW(SHW)) u_step (
    .value (sh_val),
    .kind  (sh_kind),
    .step  (step),
    .out   (step_out)
  );

  // A zero-amount shift completes like an ALU op with the source passed through.
  assign shift_now = sh_src;
  assign go_shift  = is_shift_op(op) && (amount != '0);
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_bt  = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOTA: alu_res = ~a;
      OP_PASS: alu_res = a;
      OP_SLT:  alu_res = WIDTH'(a_lt_b);
      OP_SLL, OP_SRL, OP_SRA, OP_ROTR: alu_res = shift_now;
      OP_CMP: begin
        unique case (cond)
          COND_EQ: alu_bt = (a == b);
          COND_NE: alu_bt = (a != b);
          COND_GT: alu_bt = !a_lt_b && (a != b);
          default: alu_bt = a_lt_b || (a == b);
        endcase
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      illegal      <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      zero         <= 1'b0;
      negative     <= 1'b0;
      branch_taken <= 1'b0;
`ifndef LOGIC_UNIT_BARREL_EN
      count        <= '0;
      sh_val       <= '0;
      sh_kind      <= SK_SLL;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start && go_shift) begin
`ifndef LOGIC_UNIT_BARREL_EN
            sh_val  <= sh_src;
            count   <= amount;
            sh_kind <= shift_kind(op);
`endif
            state   <= ST_SHIFT;
          end else if (start) begin
            result       <= alu_res;
            overflow     <= alu_ovf;
            zero         <= !alu_ill && (alu_res == '0);
            negative     <= alu_res[WIDTH-1];
            branch_taken <= alu_bt;
            illegal      <= alu_ill;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
`ifndef LOGIC_UNIT_BARREL_EN
        ST_SHIFT: begin
          sh_val <= step_out;
          count  <= count - step;
          if (count == step) begin
            result       <= step_out;
            overflow     <= 1'b0;
            zero         <= (step_out == '0);
            negative     <= step_out[WIDTH-1];
            branch_taken <= 1'b0;
            done         <= 1'b1;
            state        <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench: two instances (SHIFT_STEP 1 and 2) share all stimulus.
module tb_logic_unit_seq;
  import logic_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [1:0]  cond;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        shamt_src;

  logic        ready1, done1, ovf1, zero1, neg1, bt1, ill1;
  logic [31:0] res1;
  logic        ready2, done2, ovf2, zero2, neg2, bt2, ill2;
  logic [31:0] res2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        done, ready, ovf, zero, neg, bt, ill;
    logic [31:0] res;
  } obs_t;

  obs_t o1, o2;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .cond(cond), .a(a), .b(b),
    .shamt(shamt), .shamt_src(shamt_src), .ready(ready1), .done(done1), .result(res1),
    .overflow(ovf1), .zero(zero1), .negative(neg1), .branch_taken(bt1), .illegal(ill1)
  );

  logic_unit_seq #(.WIDTH(32), .SHIFT_STEP(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .op(op), .cond(cond), .a(a), .b(b),
    .shamt(shamt), .shamt_src(shamt_src), .ready(ready2), .done(done2), .result(res2),
    .overflow(ovf2), .zero(zero2), .negative(neg2), .branch_taken(bt2), .illegal(ill2)
  );

  always_comb begin
    o1.done = done1; o1.ready = ready1; o1.ovf = ovf1; o1.zero = zero1;
    o1.neg = neg1; o1.bt = bt1; o1.ill = ill1; o1.res = res1;
    o2.done = done2; o2.ready = ready2; o2.ovf = ovf2; o2.zero = zero2;
    o2.neg = neg2; o2.bt = bt2; o2.ill = ill2; o2.res = res2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input bit is_sh, input int n, input int stp);
`ifdef LOGIC_UNIT_BARREL_EN
    return 1;
`else
    if (!is_sh || n == 0) return 1;
    return 1 + (n + stp - 1) / stp;
`endif
  endfunction

  // Issue one op, wait (bounded) for done on both instances and check the captured outputs.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [1:0] cd,
                        input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sa,
                        input logic src, input logic [31:0] er, input logic eov,
                        input logic ebt, input logic eill, input int n, input int inject);
    obs_t g1, g2;
    int   l1, l2, c;
    bit   is_sh;
    logic ez;
    is_sh = (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA) || (o == OP_ROTR);
    ez    = eill ? 1'b0 : (er == 32'h0);
    g1 = '{default: '0};
    g2 = '{default: '0};
    @(negedge clk);
    op = o; cond = cd; a = av; b = bv; shamt = sa; shamt_src = src; start = 1'b1;
    l1 = 0; l2 = 0; c = 0;
    while ((l1 == 0 || l2 == 0) && c < 64) begin
      @(posedge clk); #1;
      c++;
      start = 1'b0;
      if (l1 == 0 && o1.done) begin l1 = c; g1 = o1; end
      if (l2 == 0 && o2.done) begin l2 = c; g2 = o2; end
      if (c == inject) begin op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1; end
    end
    check({tag, " s1 latency"}, 32'(l1), 32'(exp_lat(is_sh, n, 1)));
    check({tag, " s2 latency"}, 32'(l2), 32'(exp_lat(is_sh, n, 2)));
    check({tag, " s1 result"},  g1.res, er);
    check({tag, " s2 result"},  g2.res, er);
    check({tag, " s1 flags ovf/zero/neg/bt/ill"},
          {27'b0, g1.ovf, g1.zero, g1.neg, g1.bt, g1.ill},
          {27'b0, eov, ez, er[31], ebt, eill});
  endtask

  initial begin
    int dones;
    reset = 1'b0; start = 1'b0; op = '0; cond = '0; a = '0; b = '0; shamt = '0; shamt_src = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready",  {31'b0, ready1}, 32'd1);
    check("reset done",   {31'b0, done1},  32'd0);
    check("reset result", res1,            32'd0);
    check("reset flags",  {27'b0, ovf1, zero1, neg1, bt1, ill1}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    //     tag          op       cond     a             b             sa     src   result        ov bt il n   inj
    run_op("add ovf",   OP_ADD,  COND_EQ, 32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h80000000, 1, 0, 0, 0,  0);
    run_op("sub zero",  OP_SUB,  COND_EQ, 32'h00000005, 32'h00000005, 5'd0,  1'b0, 32'h00000000, 0, 0, 0, 0,  0);
    run_op("sub ovf",   OP_SUB,  COND_EQ, 32'h80000000, 32'h00000001, 5'd0,  1'b0, 32'h7FFFFFFF, 1, 0, 0, 0,  0);
    run_op("and",       OP_AND,  COND_EQ, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  1'b0, 32'h00F000F0, 0, 0, 0, 0,  0);
    run_op("or",        OP_OR,   COND_EQ, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  1'b0, 32'hFFF0FFF0, 0, 0, 0, 0,  0);
    run_op("xor",       OP_XOR,  COND_EQ, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  1'b0, 32'hFF00FF00, 0, 0, 0, 0,  0);
    run_op("not a",     OP_NOTA, COND_EQ, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  1'b0, 32'h0F0F0F0F, 0, 0, 0, 0,  0);
    run_op("pass a",    OP_PASS, COND_EQ, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  1'b0, 32'hF0F0F0F0, 0, 0, 0, 0,  0);
    run_op("sra 31",    OP_SRA,  COND_EQ, 32'h00000000, 32'h80000000, 5'd31, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 31, 0);
    run_op("rotr 4",    OP_ROTR, COND_EQ, 32'h00000000, 32'h12345678, 5'd4,  1'b0, 32'h81234567, 0, 0, 0, 4,  0);
    run_op("sll 31",    OP_SLL,  COND_EQ, 32'h00000000, 32'h00000001, 5'd31, 1'b0, 32'h80000000, 0, 0, 0, 31, 0);
    run_op("srl src1",  OP_SRL,  COND_EQ, 32'hF0000000, 32'h00000004, 5'd9,  1'b1, 32'h0F000000, 0, 0, 0, 4,  0);
    run_op("sll amt0",  OP_SLL,  COND_EQ, 32'hDEADBEEF, 32'h00000020, 5'd7,  1'b1, 32'hDEADBEEF, 0, 0, 0, 0,  0);
    run_op("cmp eq",    OP_CMP,  COND_EQ, 32'hFFFFFFFD, 32'h00000002, 5'd0,  1'b0, 32'h00000000, 0, 0, 0, 0,  0);
    run_op("cmp ne",    OP_CMP,  COND_NE, 32'hFFFFFFFD, 32'h00000002, 5'd0,  1'b0, 32'h00000000, 0, 1, 0, 0,  0);
    run_op("cmp gt",    OP_CMP,  COND_GT, 32'hFFFFFFFD, 32'h00000002, 5'd0,  1'b0, 32'h00000000, 0, 0, 0, 0,  0);
    run_op("cmp le",    OP_CMP,  COND_LE, 32'hFFFFFFFD, 32'h00000002, 5'd0,  1'b0, 32'h00000000, 0, 1, 0, 0,  0);
    run_op("slt",       OP_SLT,  COND_EQ, 32'hFFFFFFFD, 32'h00000002, 5'd0,  1'b0, 32'h00000001, 0, 0, 0, 0,  0);
    run_op("reserved",  4'hE,    COND_EQ, 32'h12345678, 32'h9ABCDEF0, 5'd0,  1'b0, 32'h00000000, 0, 0, 1, 0,  0);
    // A start injected two cycles into the shift must be ignored by both instances.
    run_op("srl busy",  OP_SRL,  COND_EQ, 32'h00000000, 32'h80000000, 5'd8,  1'b0, 32'h00800000, 0, 0, 0, 8,  2);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'b0;
      dones += int'(done1) + int'(done2);
    end
    check("busy start no extra done", 32'(dones), 32'd0);

    // Back-to-back: ADD then SLL accepted in the DONE cycle with start held high.
    @(negedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd2; shamt_src = 1'b0; shamt = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    check("b2b add done",   {31'b0, done1}, 32'd1);
    check("b2b add result", res1,           32'd3);
    op = OP_SLL; b = 32'd3; shamt = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
`ifndef LOGIC_UNIT_BARREL_EN
    check("b2b sll accepted", {30'b0, ready1, ready2}, 32'd0);
    check("b2b sll no done",  {31'b0, done1},          32'd0);
    @(posedge clk); #1;
`endif
    check("b2b sll done pair", {30'b0, done1, done2}, 32'd3);
    check("b2b sll result",    res1,                  32'd6);

    // Reset asserted in the third cycle of an SRL by 20.
    @(negedge clk);
    op = OP_SRL; b = 32'hFFFFFFFF; shamt = 5'd20; shamt_src = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid-shift reset ready",  {30'b0, ready1, ready2}, 32'd3);
    check("mid-shift reset done",   {30'b0, done1, done2},   32'd0);
    check("mid-shift reset result", res1 | res2,             32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      dones += int'(done1) + int'(done2);
    end
    check("no late done after reset", 32'(dones), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
